// File: rtl/multdiv_iter_if.sv
// Start/operand/result bundle for the iterative multiply/divide unit.
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Requester side: issues starts and operands, consumes results.
  modport master (
    output ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    input  data_result, data_result_hi, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
    output data_result, data_result_hi, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiply (Booth) / divide (restoring) unit.
// WIDTH must be even and in 8..64. A start is sampled at edge t; RUN performs
// one step per edge t+1..t+WIDTH, FIX forms the final values, and the
// registered status outputs (busy, data_resultRDY) trail the state by one
// cycle, so RDY appears after edge t+WIDTH+2 and busy spans WIDTH+1 cycles.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  typedef struct packed {
    logic             mul;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t state, state_nx;
  op_t    op;

  logic start;
  logic step_en, fix_en, busy_d, rdy_d;
  logic [CW-1:0] cnt;

  // Working registers: acc is the Booth accumulator (two guard bits keep the
  // arithmetic shift's sign exact) or the divide remainder in its low bits;
  // lo is the multiplier / dividend-then-quotient shift register.
  logic [WIDTH+1:0] acc, acc_nx;
  logic [WIDTH-1:0] lo, lo_nx;
  logic             qm1, qm1_nx;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH+1:0] mcand, booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0] fix_lo, fix_hi;
  logic             fix_exc;
  logic             q_neg, r_neg, div_zero, div_ovf;

  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             exc_q, rdy_q, busy_q;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; any start restarts the sequence from RUN.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        IDLE:    state_nx = IDLE;
        RUN:     state_nx = (cnt == CW'(WIDTH-1)) ? FIX : RUN;
        FIX:     state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode; a start in the same cycle suppresses the old op's actions.
  always_comb begin
    step_en = 1'b0;
    fix_en  = 1'b0;
    busy_d  = 1'b0;
    rdy_d   = 1'b0;
    unique case (state)
      RUN:  begin step_en = ~start; busy_d = 1'b1; end
      FIX:  begin fix_en  = ~start; busy_d = 1'b1; end
      DONE: rdy_d = ~start;
      default: ;
    endcase
  end

  // Operand magnitudes for the divide path, taken at the start pulse.
  always_comb begin
    a_neg = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
    b_neg = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
    a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
    b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;
  end

  // One radix-2 step of whichever operation is latched.
  always_comb begin
    mcand     = op.sgn ? {{2{op.a[WIDTH-1]}}, op.a} : {2'b00, op.a};
    booth_sum = acc;
    div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - dvs;
    div_ge    = (div_shift >= {1'b0, dvs});
    acc_nx    = acc;
    lo_nx     = lo;
    qm1_nx    = qm1;
    if (op.mul) begin
      unique case ({lo[0], qm1})
        2'b10:   booth_sum = acc - mcand;
        2'b01:   booth_sum = acc + mcand;
        default: booth_sum = acc;
      endcase
      acc_nx = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
      lo_nx  = {booth_sum[0], lo[WIDTH-1:1]};
      qm1_nx = lo[0];
    end else begin
      acc_nx = {2'b00, (div_ge ? div_diff : div_shift[WIDTH-1:0])};
      lo_nx  = {lo[WIDTH-2:0], div_ge};
    end
  end

  // Final corrections. Booth treats the multiplier as signed, so an unsigned
  // multiplier with its top bit set needs A added into the high half.
  always_comb begin
    q_neg    = op.sgn & (op.a[WIDTH-1] ^ op.b[WIDTH-1]);
    r_neg    = op.sgn & op.a[WIDTH-1];
    div_zero = (op.b == '0);
    div_ovf  = op.sgn & (op.a == {1'b1, {(WIDTH-1){1'b0}}}) & (op.b == '1);
    if (op.mul) begin
      fix_lo  = lo;
      fix_hi  = acc[WIDTH-1:0] + ((!op.sgn && op.b[WIDTH-1]) ? op.a : '0);
      fix_exc = op.sgn ? (fix_hi != {WIDTH{lo[WIDTH-1]}}) : (fix_hi != '0);
    end else if (div_zero) begin
      fix_lo  = '0;
      fix_hi  = op.a;
      fix_exc = 1'b1;
    end else begin
      fix_lo  = q_neg ? -lo : lo;
      fix_hi  = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_exc = div_ovf;
    end
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      op  <= '0;
      acc <= '0;
      lo  <= '0;
      qm1 <= 1'b0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      op.mul <= bus.ctrl_MULT;
      op.sgn <= bus.ctrl_signed;
      op.a   <= bus.data_operandA;
      op.b   <= bus.data_operandB;
      acc    <= '0;
      lo     <= bus.ctrl_MULT ? bus.data_operandB : a_mag;
      qm1    <= 1'b0;
      dvs    <= b_mag;
      cnt    <= '0;
    end else if (step_en) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      qm1 <= qm1_nx;
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers load on entry to DONE; status flags trail the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_q    <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (fix_en) begin
        res_q    <= fix_lo;
        res_hi_q <= fix_hi;
        exc_q    <= fix_exc;
      end
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_result_hi = res_hi_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter at WIDTH=32.
module tb_multdiv_iter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  multdiv_iter_if #(.WIDTH(32)) bus ();

  multdiv_iter #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one op and watch 60 cycles after the sampling edge: first RDY
  // cycle, RDY pulse length, busy cycle count and the values at RDY.
  task automatic run_op(input logic mul, input logic div, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] hi,
                        output logic exc, output int rdy_cyc,
                        output int busy_cnt, output int rdy_len);
    @(posedge clock); #1;
    bus.ctrl_MULT = mul; bus.ctrl_DIV = div; bus.ctrl_signed = sgn;
    bus.data_operandA = a; bus.data_operandB = b;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    rdy_cyc = -1; busy_cnt = 0; rdy_len = 0;
    res = 32'hx; hi = 32'hx; exc = 1'bx;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clock); #1;
      if (bus.busy) busy_cnt++;
      if (bus.data_resultRDY) begin
        rdy_len++;
        if (rdy_cyc < 0) begin
          rdy_cyc = cyc;
          res = bus.data_result; hi = bus.data_result_hi; exc = bus.data_exception;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ctrl_MULT = 1'b1; bus.ctrl_DIV = 1'b0; bus.ctrl_signed = 1'b0;
    bus.data_operandA = 32'd5; bus.data_operandB = 32'd5;
    repeat (3) @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    checks++; if (bus.data_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", bus.data_result, 32'h0); end
    checks++; if (bus.data_result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.data_result_hi, 32'h0); end
    checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_mult_signed;
    logic [31:0] r, h; logic e; int rc, bc, rl;
    run_op(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL smul_lo: got %h expected %h", r, 32'hFFFFFFEB); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL smul_hi: got %h expected %h", h, 32'hFFFFFFFF); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL smul_exc: got %b expected 0", e); end
    checks++; if (rc != 34) begin errors++; $display("FAIL smul_latency: got %0d expected 34", rc); end
    checks++; if (bc != 33) begin errors++; $display("FAIL smul_busy_cycles: got %0d expected 33", bc); end
    checks++; if (rl != 1) begin errors++; $display("FAIL smul_rdy_len: got %0d expected 1", rl); end
    checks++; if (bus.data_result !== 32'hFFFFFFEB) begin errors++; $display("FAIL smul_hold: got %h expected %h", bus.data_result, 32'hFFFFFFEB); end
  endtask

  task automatic test_mult_overflow;
    logic [31:0] r, h; logic e; int rc, bc, rl;
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL umul_lo: got %h expected %h", r, 32'hFFFFFFFE); end
    checks++; if (h !== 32'h00000001) begin errors++; $display("FAIL umul_hi: got %h expected %h", h, 32'h1); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL umul_exc: got %b expected 1", e); end
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL smul2_lo: got %h expected %h", r, 32'hFFFFFFFE); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL smul2_hi: got %h expected %h", h, 32'hFFFFFFFF); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL smul2_exc: got %b expected 0", e); end
    // Unsigned multiplier with its top bit set.
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL umax_lo: got %h expected %h", r, 32'h1); end
    checks++; if (h !== 32'hFFFFFFFE) begin errors++; $display("FAIL umax_hi: got %h expected %h", h, 32'hFFFFFFFE); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL umax_exc: got %b expected 1", e); end
  endtask

  task automatic test_div;
    logic [31:0] r, h; logic e; int rc, bc, rl;
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL sdiv_q: got %h expected %h", r, 32'hFFFFFFFD); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL sdiv_r: got %h expected %h", h, 32'hFFFFFFFF); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sdiv_exc: got %b expected 0", e); end
    run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL udiv_q: got %h expected %h", r, 32'd14); end
    checks++; if (h !== 32'd2) begin errors++; $display("FAIL udiv_r: got %h expected %h", h, 32'd2); end
    checks++; if (rc != 34) begin errors++; $display("FAIL udiv_latency: got %0d expected 34", rc); end
  endtask

  task automatic test_div_exc;
    logic [31:0] r, h; logic e; int rc, bc, rl;
    run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL dz_q: got %h expected %h", r, 32'd0); end
    checks++; if (h !== 32'd5) begin errors++; $display("FAIL dz_r: got %h expected %h", h, 32'd5); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dz_exc: got %b expected 1", e); end
    checks++; if (rc != 34) begin errors++; $display("FAIL dz_latency: got %0d expected 34", rc); end
    run_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL ovf_q: got %h expected %h", r, 32'h80000000); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL ovf_r: got %h expected %h", h, 32'd0); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_exc: got %b expected 1", e); end
  endtask

  // Divide started at cycle 0, multiply restarts it at cycle 10.
  task automatic test_restart;
    int rdy_cnt, rdy_at; logic [31:0] r;
    rdy_cnt = 0; rdy_at = -1; r = 32'hx;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b1; bus.ctrl_signed = 1'b0;
    bus.data_operandA = 32'd100; bus.data_operandB = 32'd7;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc == 10) begin
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd3; bus.data_operandB = 32'd4;
      end
      @(posedge clock); #1;
      bus.ctrl_MULT = 1'b0;
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at < 0) begin rdy_at = cyc; r = bus.data_result; end
      end
    end
    checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL restart_rdy_count: got %0d expected 1", rdy_cnt); end
    checks++; if (rdy_at != 44) begin errors++; $display("FAIL restart_rdy_cycle: got %0d expected 44", rdy_at); end
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL restart_result: got %h expected %h", r, 32'd12); end
  endtask

  // Reset sampled at cycle 20 of a multiply.
  task automatic test_reset_mid;
    int rdy_cnt;
    rdy_cnt = 0;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b1; bus.ctrl_signed = 1'b0;
    bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 20) reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      if (bus.data_resultRDY) rdy_cnt++;
      if (cyc == 20) begin
        checks++; if (bus.data_result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected %h", bus.data_result, 32'h0); end
        checks++; if (bus.data_result_hi !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h expected %h", bus.data_result_hi, 32'h0); end
        checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL midrst_exc: got %b expected 0", bus.data_exception); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
      end
    end
    checks++; if (rdy_cnt != 0) begin errors++; $display("FAIL midrst_rdy: got %0d expected 0", rdy_cnt); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] r, h; logic e; int rc, bc, rl;
    run_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd3, r, h, e, rc, bc, rl);
    checks++; if (r !== 32'd18) begin errors++; $display("FAIL both_lo: got %h expected %h", r, 32'd18); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL both_hi: got %h expected %h", h, 32'd0); end
    checks++; if (rc != 34) begin errors++; $display("FAIL both_latency: got %0d expected 34", rc); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0; bus.ctrl_signed = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    test_reset;
    test_mult_signed;
    test_mult_overflow;
    test_div;
    test_div_exc;
    test_reset_mid;
    test_restart;
    test_simultaneous;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
